// File: rtl/gmsk_burst_sequencer_if.sv
// Burst-sequencer bus: buffer write port, burst start, modulator symbol
// handshake and the status/symbol outputs back to the modulator.
//   master : drives wr_en, wr_addr, wr_data, start, next_symbol_strobe
//   slave  : drives sample_strobe, current_symbol, busy, in_payload, done
interface gmsk_burst_sequencer_if;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic       wr_data;
  logic       start;
  logic       next_symbol_strobe;
  logic       sample_strobe;
  logic       current_symbol;
  logic       busy;
  logic       in_payload;
  logic       done;

  modport master (
    output wr_en, wr_addr, wr_data, start, next_symbol_strobe,
    input  sample_strobe, current_symbol, busy, in_payload, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, next_symbol_strobe,
    output sample_strobe, current_symbol, busy, in_payload, done
  );
endinterface

// File: rtl/gmsk_burst_sequencer.sv
// GMSK burst sequencer: buffers one raw payload burst, then on start emits
// GUARD_BITS zero symbols, BURST_BITS differentially encoded payload
// symbols and GUARD_BITS zero symbols, one per modulator symbol request.
// A free-running divider supplies the modulator sample strobe.
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : slave side of gmsk_burst_sequencer_if (write port, start,
//           symbol strobe in; sample strobe, symbol, status out)
module gmsk_burst_sequencer #(
  parameter int SAMPLE_DIV = 12,
  parameter int BURST_BITS = 148,
  parameter int GUARD_BITS = 8
) (
  input logic                    clock,
  input logic                    reset,
  gmsk_burst_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, GUARD_PRE, PAYLOAD, GUARD_POST} state_t;

  localparam int         AW         = (BURST_BITS > 1) ? $clog2(BURST_BITS) : 1;
  localparam logic [7:0] DIV_LAST   = 8'(SAMPLE_DIV - 1);
  localparam logic [8:0] GUARD_LAST = 9'(GUARD_BITS - 1);
  localparam logic [8:0] BURST_N    = 9'(BURST_BITS);

  // Sample divider, independent of the burst FSM.
  logic [7:0] div_q, div_d;
  logic       sample_q;

  always_comb div_d = (div_q == DIV_LAST) ? '0 : div_q + 8'd1;

  // Strobe is registered from the next count so it is high exactly while
  // the counter sits at SAMPLE_DIV-1.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_q    <= '0;
      sample_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      sample_q <= (div_d == DIV_LAST);
    end
  end

  // Burst buffer; deliberately not cleared by reset.
  logic [BURST_BITS-1:0] burst_buf;
  state_t                state_q, state_d;
  logic                  wr_ok;

  always_comb wr_ok = (state_q == IDLE) && bus.wr_en && ({1'b0, bus.wr_addr} < BURST_N);

  always_ff @(posedge clock) begin
    if (!reset && wr_ok)
      burst_buf[bus.wr_addr[AW-1:0]] <= bus.wr_data;
  end

  // Burst FSM.
  logic [8:0] guard_q, guard_d;
  logic [8:0] index_q, index_d;
  logic       prev_q, prev_d;
  logic       sym_q, sym_d;
  logic       busy_q, in_payload_q, done_q, done_d;
  logic       cur_bit;

  always_comb cur_bit = burst_buf[index_q[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      guard_q      <= '0;
      index_q      <= '0;
      prev_q       <= 1'b1;
      sym_q        <= 1'b0;
      busy_q       <= 1'b0;
      in_payload_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      guard_q      <= guard_d;
      index_q      <= index_d;
      prev_q       <= prev_d;
      sym_q        <= sym_d;
      busy_q       <= (state_d != IDLE);
      in_payload_q <= (state_d == PAYLOAD);
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    index_d = index_q;
    prev_d  = prev_q;
    sym_d   = sym_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = GUARD_PRE;
          guard_d = '0;
          sym_d   = 1'b0;
        end
      end
      GUARD_PRE: begin
        if (bus.next_symbol_strobe) begin
          if (guard_q == GUARD_LAST) begin
            // First payload symbol is encoded against an implicit 1.
            state_d = PAYLOAD;
            sym_d   = burst_buf[0] ^ 1'b1;
            prev_d  = burst_buf[0];
            index_d = 9'd1;
          end else begin
            guard_d = guard_q + 9'd1;
          end
        end
      end
      PAYLOAD: begin
        if (bus.next_symbol_strobe) begin
          if (index_q < BURST_N) begin
            sym_d   = cur_bit ^ prev_q;
            prev_d  = cur_bit;
            index_d = index_q + 9'd1;
          end else begin
            state_d = GUARD_POST;
            sym_d   = 1'b0;
            guard_d = '0;
          end
        end
      end
      GUARD_POST: begin
        if (bus.next_symbol_strobe) begin
          if (guard_q == GUARD_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            guard_d = guard_q + 9'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.sample_strobe  = sample_q;
  assign bus.current_symbol = sym_q;
  assign bus.busy           = busy_q;
  assign bus.in_payload     = in_payload_q;
  assign bus.done           = done_q;

endmodule

// File: tb/tb_gmsk_burst_sequencer.sv
module tb_gmsk_burst_sequencer;

  localparam int SD = 4;
  localparam int BB = 148;
  localparam int GB = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  gmsk_burst_sequencer_if bus();

  gmsk_burst_sequencer #(
    .SAMPLE_DIV(SD),
    .BURST_BITS(BB),
    .GUARD_BITS(GB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Cycles since the last reset edge; the divider must never realign to start.
  always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

  typedef struct {
    logic sym;
    logic inpl;
    logic busy;
    logic done;
  } exp_t;

  exp_t sb[$];
  logic mbuf[BB];
  logic last_sym = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check_value(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check_value({tag, "_queue_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check_value({tag, "_sym"},    bus.current_symbol, e.sym);
      check_value({tag, "_inpl"},   bus.in_payload,     e.inpl);
      check_value({tag, "_busy"},   bus.busy,           e.busy);
      check_value({tag, "_done"},   bus.done,           e.done);
      check_value({tag, "_sample"}, bus.sample_strobe,  int'((cyc % SD) == SD - 1));
      last_sym = e.sym;
    end
  endtask

  task automatic write_bit(input int addr, input logic d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 8'(addr);
    bus.wr_data = d;
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic run_burst(input int abort_k, input bit flip_in_start, input bit disturb);
    logic enc[BB];
    logic p;
    exp_t e;
    int   last;
    int   gap;
    bit   inp;
    last = 2 * GB + BB;

    bus.start = 1'b1;
    if (flip_in_start) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 8'd0;
      bus.wr_data = ~mbuf[0];
      mbuf[0]     = ~mbuf[0];
    end
    p = 1'b1;
    for (int i = 0; i < BB; i++) begin
      enc[i] = mbuf[i] ^ p;
      p      = mbuf[i];
    end
    sb.push_back('{sym: 1'b0, inpl: 1'b0, busy: 1'b1, done: 1'b0});
    step();
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    pop_check("start");

    for (int k = 1; k <= last; k++) begin
      gap = $urandom_range(0, 3);
      if (disturb && k == 20) gap = 2;
      for (int g = 0; g < gap; g++) begin
        if (disturb && k == 20 && g == 0) bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check_value("hold_sym",  bus.current_symbol, last_sym);
        check_value("hold_busy", bus.busy, 1);
      end
      bus.next_symbol_strobe = 1'b1;
      if (disturb && k == GB + 60) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = 8'd5;
        bus.wr_data = ~mbuf[5];
      end
      if (k == abort_k) begin
        reset = 1'b1;
        sb.push_back('{sym: 1'b0, inpl: 1'b0, busy: 1'b0, done: 1'b0});
      end else begin
        inp    = (k >= GB) && (k < GB + BB);
        e.sym  = inp ? enc[k - GB] : 1'b0;
        e.inpl = inp;
        e.busy = (k < last);
        e.done = (k == last);
        sb.push_back(e);
      end
      step();
      bus.next_symbol_strobe = 1'b0;
      bus.wr_en = 1'b0;
      reset = 1'b0;
      pop_check(k == abort_k ? "abort" : "strobe");
      if (k == abort_k) begin
        for (int j = 0; j < 3; j++) begin
          step();
          check_value("abort_busy", bus.busy, 0);
          check_value("abort_done", bus.done, 0);
          check_value("abort_sym",  bus.current_symbol, 0);
        end
        return;
      end
    end
    for (int j = 0; j < 2; j++) begin
      step();
      check_value("done_single", bus.done, 0);
      check_value("idle_busy",   bus.busy, 0);
    end
  endtask

  initial begin
    bus.wr_en              = 1'b0;
    bus.wr_addr            = '0;
    bus.wr_data            = 1'b0;
    bus.start              = 1'b0;
    bus.next_symbol_strobe = 1'b0;
    reset                  = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_value("rst_sym",    bus.current_symbol, 0);
    check_value("rst_busy",   bus.busy, 0);
    check_value("rst_inpl",   bus.in_payload, 0);
    check_value("rst_done",   bus.done, 0);
    check_value("rst_sample", bus.sample_strobe, 0);

    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check_value("div_phase", bus.sample_strobe, int'((i % 4) == 3));
      step();
    end

    bus.next_symbol_strobe = 1'b1;
    step();
    bus.next_symbol_strobe = 1'b0;
    check_value("idle_strobe_busy", bus.busy, 0);
    check_value("idle_strobe_sym",  bus.current_symbol, 0);

    for (int a = 0; a < BB; a++) begin
      mbuf[a] = 1'b1;
      write_bit(a, 1'b1);
    end
    run_burst(0, 1'b0, 1'b0);

    for (int a = 0; a < BB; a++) begin
      mbuf[a] = logic'(a % 2);
      write_bit(a, logic'(a % 2));
    end
    run_burst(0, 1'b0, 1'b1);
    run_burst(0, 1'b0, 1'b0);

    run_burst(GB + 49, 1'b0, 1'b0);
    run_burst(0, 1'b0, 1'b0);

    run_burst(0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
